divisor_kca: RTL and testbench
==============================

// Module: divisor_kca
// PURPOSE
//   Sequential restoring divider, the inverse companion of the 8x8 shift-add multiplier.
//   Divides an unsigned dividend by an unsigned divisor, producing one quotient bit per clock.
//   Uses the same Start/Ready handshake as the multiplier, so the two blocks share one controller.
//   Intended for checking products (product / multiplicand = multiplier, remainder 0) and for general division.
// PARAMETERS
//   N_DIVIDENDO  16  dividend and quotient width (bits)
//   N_DIVISOR     8  divisor and remainder width (bits)
// PORTS
//   Clock         in   1             single clock, rising edge
//   Reset         in   1             synchronous, active-high
//   Start         in   1             request; sampled on rising edge
//   Dividendo     in   N_DIVIDENDO   unsigned dividend
//   Divisor       in   N_DIVISOR     unsigned divisor
//   Cociente      out  N_DIVIDENDO   quotient, registered
//   Residuo       out  N_DIVISOR     remainder, registered
//   Ready         out  1             results valid; high until next accepted Start
//   Error         out  1             divide-by-zero flag; valid while Ready=1
// BEHAVIOUR
//   - One clock domain. Reset is synchronous and active-high.
//   - Reset (any state, including mid-division): at the next edge, state=IDLE, Cociente=0, Residuo=0,
//     Ready=0, Error=0, and all internal registers are cleared.
//   - States: IDLE -> CALC -> DONE -> (CALC on Start | stays DONE). Zero divisor: IDLE/DONE -> DZ -> DONE.
//   - Start is accepted only in IDLE or DONE. Start during CALC/DZ is ignored and does not restart or queue.
//   - Accept edge N: latch Dividendo/Divisor, clear the partial remainder R (N_DIVISOR+1 bits),
//     set counter=0, drop Ready and Error. Operand changes after edge N have no effect.
//   - CALC, one step per edge:
//     - R = {R[N_DIVISOR-1:0], Q[MSB]}; Q <<= 1.
//     - If R >= {0,D}: R -= D and Q[0]=1; otherwise Q[0]=0.
//     - The counter runs 0..N_DIVIDENDO-1. The step at edge N+16 is the last one; then state=DONE.
//   - Outputs are loaded from the working registers on the DONE entry edge. Cociente, Residuo and Ready=1
//     are visible after edge N+17, so latency is 17 cycles from the accept edge.
//   - Divide by zero (Divisor==0 at accept): no iteration. At edge N+1 go to DZ. At edge N+2 go to DONE
//     with Cociente={N_DIVIDENDO{1}}, Residuo=Dividendo[N_DIVISOR-1:0], Error=1, Ready=1.
//   - Outputs hold steady in DONE. Start held high in DONE re-accepts each time DONE is reached (back-to-back).
//   - All arithmetic is unsigned. R never exceeds 2*D-1, so N_DIVISOR+1 bits is sufficient.
//   - The quotient covers the full N_DIVIDENDO range with no overflow (e.g. FFFF/01 = FFFF).
// STRUCTURE
//   - Package kca_pkg: state encodings (IDLE, CALC, DZ, DONE), N_DIVIDENDO/N_DIVISOR defaults,
//     counter width = $clog2(N_DIVIDENDO). This package is shared with the multiplier controller.
//   - Sub-module divisor_kca_etapa: combinational single restoring step.
//     Inputs R, Q_msb, D. Outputs R_next, q_bit.
//   - Top level holds the FSM, counter, operand/working registers and output registers.
// TESTING
//   1) 0xBB49 / 0xDF -> Cociente=0x00D7, Residuo=0x00, Error=0; Ready rises 17 cycles after accept
//      (inverse of 0xD7*0xDF).
//   2) 50000 / 199 -> Cociente=251, Residuo=51. Then 1000 / 7 -> 142 rem 6, started back-to-back
//      with Start held high.
//   3) 0xFFFF / 0x01 -> Cociente=0xFFFF, Residuo=0. Also 0x0005 / 0xFF -> Cociente=0, Residuo=5.
//   4) 0x1234 / 0x00 -> Error=1, Cociente=0xFFFF, Residuo=0x34, Ready high 2 cycles after accept.
//   5) Start pulsed at iteration 5 of an active division -> ignored; first result unchanged, latency still 17.
//   6) Reset asserted at iteration 8 -> next edge all outputs 0, Ready=0. A new Start then gives a correct result.

Source files
------------

// File: rtl/kca_pkg.sv
// Shared definitions for the kca multiply/divide pair: controller state
// encodings, default operand widths and the iteration counter width.
package kca_pkg;

  localparam int N_DIVIDENDO_DEF = 16;
  localparam int N_DIVISOR_DEF   = 8;
  localparam int CNT_W           = $clog2(N_DIVIDENDO_DEF);

  // DZ is a single settle cycle used only when the divisor is zero
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DZ   = 2'd2,
    DONE = 2'd3
  } kca_state_t;

endpackage

// File: rtl/divisor_kca_etapa.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor when it fits and report the quotient bit.
module divisor_kca_etapa
  import kca_pkg::*;
#(
  parameter int N_DIVISOR = N_DIVISOR_DEF
) (
  input  logic [N_DIVISOR:0]   r,
  input  logic                 q_msb,
  input  logic [N_DIVISOR-1:0] d,
  output logic [N_DIVISOR:0]   r_next,
  output logic                 q_bit
);

  logic [N_DIVISOR+1:0] trial;
  logic [N_DIVISOR+1:0] d_ext;

  assign trial = {r, q_msb};
  assign d_ext = {2'b00, d};

  // r stays below d between steps, so the difference always fits back into r
  always_comb begin
    r_next = trial[N_DIVISOR:0];
    q_bit  = 1'b0;
    if (trial >= d_ext) begin
      r_next = (N_DIVISOR+1)'(trial - d_ext);
      q_bit  = 1'b1;
    end
  end

endmodule

// File: rtl/divisor_kca.sv
// Sequential restoring divider producing one quotient bit per clock, sharing
// the start/ready handshake of the kca shift-add multiplier.
module divisor_kca
  import kca_pkg::*;
#(
  parameter int N_DIVIDENDO = N_DIVIDENDO_DEF,
  parameter int N_DIVISOR   = N_DIVISOR_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [N_DIVIDENDO-1:0] dividendo,
  input  logic [N_DIVISOR-1:0]   divisor,
  output logic [N_DIVIDENDO-1:0] cociente,
  output logic [N_DIVISOR-1:0]   residuo,
  output logic                   ready,
  output logic                   error
);

  localparam int CW = $clog2(N_DIVIDENDO);

  kca_state_t state, state_next;

  logic [N_DIVIDENDO-1:0] q_work;
  logic [N_DIVISOR:0]     r_work;
  logic [N_DIVISOR-1:0]   d_reg;
  logic [CW-1:0]          count;
  logic                   steps_done;

  logic                   accept;
  logic                   div_zero;
  logic [N_DIVISOR:0]     r_next;
  logic                   q_bit;

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign div_zero = (d_reg == '0);

  divisor_kca_etapa #(
    .N_DIVISOR (N_DIVISOR)
  ) u_etapa (
    .r      (r_work),
    .q_msb  (q_work[N_DIVIDENDO-1]),
    .d      (d_reg),
    .r_next (r_next),
    .q_bit  (q_bit)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // CALC lingers one edge after the last step so the results load on DONE entry
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, DONE: if (start) state_next = CALC;
      CALC: begin
        if (div_zero)        state_next = DZ;
        else if (steps_done) state_next = DONE;
      end
      DZ:      state_next = DONE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      q_work     <= '0;
      r_work     <= '0;
      d_reg      <= '0;
      count      <= '0;
      steps_done <= 1'b0;
      cociente   <= '0;
      residuo    <= '0;
      ready      <= 1'b0;
      error      <= 1'b0;
    end else if (accept) begin
      q_work     <= dividendo;
      r_work     <= '0;
      d_reg      <= divisor;
      count      <= '0;
      steps_done <= 1'b0;
      ready      <= 1'b0;
      error      <= 1'b0;
    end else if (state == CALC && !div_zero) begin
      if (!steps_done) begin
        r_work <= r_next;
        q_work <= {q_work[N_DIVIDENDO-2:0], q_bit};
        count  <= count + 1'b1;
        if (count == CW'(N_DIVIDENDO - 1)) steps_done <= 1'b1;
      end else begin
        cociente <= q_work;
        residuo  <= r_work[N_DIVISOR-1:0];
        ready    <= 1'b1;
      end
    end else if (state == DZ) begin
      // q_work still holds the untouched dividend here
      cociente <= '1;
      residuo  <= q_work[N_DIVISOR-1:0];
      error    <= 1'b1;
      ready    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_divisor_kca.sv
// Randomised and directed checks of divisor_kca against a plain-arithmetic
// division model, covering latency, handshake, divide-by-zero and reset.
module tb_divisor_kca;

  logic        clock;
  logic        reset;
  logic        start;
  logic [15:0] dividendo;
  logic [7:0]  divisor;
  logic [15:0] cociente;
  logic [7:0]  residuo;
  logic        ready;
  logic        error;

  int compared   = 0;
  int mismatched = 0;

  divisor_kca dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .dividendo (dividendo),
    .divisor   (divisor),
    .cociente  (cociente),
    .residuo   (residuo),
    .ready     (ready),
    .error     (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Behavioural reference: plain integer division, all-ones quotient on zero divisor
  task automatic refDiv(input int a, input int b, output int q, output int r, output int e);
    if (b == 0) begin
      q = 'hFFFF;
      r = a % 256;
      e = 1;
    end else begin
      q = a / b;
      r = a % b;
      e = 0;
    end
  endtask

  // Count edges after the accept edge until ready rises, bounded
  task automatic waitReady(output int lat);
    lat = 0;
    while (!ready && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic checkResult(input string tag, input int a, input int b, input int lat);
    int q, r, e;
    refDiv(a, b, q, r, e);
    checkOutput({tag, ".latency"}, lat, (b == 0) ? 2 : 17);
    checkOutput({tag, ".cociente"}, cociente, q);
    checkOutput({tag, ".residuo"}, residuo, r);
    checkOutput({tag, ".error"}, error, e);
  endtask

  // One division; optional Start pulse injected pokeAt edges after acceptance
  task automatic applyStimulus(input string tag, input logic [15:0] a,
                               input logic [7:0] b, input int pokeAt);
    int lat;
    logic [15:0] qHold;
    @(negedge clock);
    dividendo = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start     = 1'b0;
    dividendo = 16'($urandom);
    divisor   = 8'($urandom);
    checkOutput({tag, ".readyDrop"}, ready, 0);
    lat = 0;
    while (!ready && lat < 40) begin
      start = (lat == pokeAt);
      if (lat == pokeAt) begin
        dividendo = 16'($urandom);
        divisor   = 8'($urandom);
      end
      @(posedge clock);
      #1;
      lat++;
    end
    start = 1'b0;
    checkResult(tag, int'(a), int'(b), lat);
    qHold = cociente;
    @(posedge clock);
    #1;
    checkOutput({tag, ".holdReady"}, ready, 1);
    checkOutput({tag, ".holdCociente"}, cociente, qHold);
  endtask

  initial begin
    int lat;
    logic [15:0] ra;
    logic [7:0]  rb;

    reset = 1'b1;
    start = 1'b0;
    dividendo = '0;
    divisor = '0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset.ready", ready, 0);
    checkOutput("reset.cociente", cociente, 0);
    checkOutput("reset.residuo", residuo, 0);
    reset = 1'b0;

    applyStimulus("inverseMul", 16'hBB49, 8'hDF, -1);
    applyStimulus("fullRange", 16'hFFFF, 8'h01, -1);
    applyStimulus("smallDividend", 16'h0005, 8'hFF, -1);
    applyStimulus("divZero", 16'h1234, 8'h00, -1);
    applyStimulus("ignoredStart", 16'd40000, 8'd123, 5);

    // Back-to-back with Start held high through the first division
    @(negedge clock);
    dividendo = 16'd50000;
    divisor   = 8'd199;
    start     = 1'b1;
    @(posedge clock);
    #1;
    dividendo = 16'd1000;
    divisor   = 8'd7;
    waitReady(lat);
    checkResult("b2bFirst", 50000, 199, lat);
    @(posedge clock);
    #1;
    start = 1'b0;
    checkOutput("b2b.readyDrop", ready, 0);
    waitReady(lat);
    checkResult("b2bSecond", 1000, 7, lat);

    // Reset in the middle of a division
    @(negedge clock);
    dividendo = 16'hABCD;
    divisor   = 8'h13;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("midReset.ready", ready, 0);
    checkOutput("midReset.cociente", cociente, 0);
    checkOutput("midReset.residuo", residuo, 0);
    checkOutput("midReset.error", error, 0);
    applyStimulus("afterReset", 16'hABCD, 8'h13, -1);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 8'h00;
        1:       rb = 8'($urandom_range(1, 3));
        default: rb = 8'($urandom);
      endcase
      applyStimulus("random", ra, rb, (i % 5 == 0) ? int'($urandom_range(0, 15)) : -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
